// File: rtl/dtt_xbar_scheduler.sv
// dtt_xbar_scheduler
// Credit-aware round-robin crossbar scheduler. Each output picks one requesting
// input per cycle, scanning from its round-robin pointer, as long as it holds at
// least one downstream credit. Grants (in_ready) are combinational. The crossbar
// select/valid lines are registered and lag the grant by one cycle. A credit
// returned to an output that is already full raises a sticky overflow flag.
module dtt_xbar_scheduler #(
   parameter int N_IN    = 4,
   parameter int N_OUT   = 4,
   parameter int CREDITS = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid        [0:N_IN-1],
   input  logic [$clog2(N_OUT)-1:0] in_dest         [0:N_IN-1],
   output logic                     in_ready        [0:N_IN-1],
   input  logic                     credit_return   [0:N_OUT-1],
   output logic [$clog2(N_IN)-1:0]  xbar_sel        [0:N_OUT-1],
   output logic                     xbar_valid      [0:N_OUT-1],
   output logic                     credit_overflow
);

   localparam int SW = $clog2(N_IN);
   localparam int DW = $clog2(N_OUT);
   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);
   localparam logic [CW-1:0] CRED_ONE  = CW'(1);

   // (base + k) mod N_IN, valid for 0 <= k < N_IN; works for non-power-of-two N_IN
   function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_IN) begin
         s = s - N_IN;
      end else begin
         s = s;
      end
      return SW'(s);
   endfunction

   // per-output state
   logic [SW-1:0] rr_ptr_q   [0:N_OUT-1];
   logic [SW-1:0] rr_ptr_d   [0:N_OUT-1];
   logic [CW-1:0] credit_q   [0:N_OUT-1];
   logic [CW-1:0] credit_d   [0:N_OUT-1];
   logic [SW-1:0] xsel_q     [0:N_OUT-1];
   logic [SW-1:0] xsel_d     [0:N_OUT-1];
   logic          xvalid_q   [0:N_OUT-1];
   logic          xvalid_d   [0:N_OUT-1];
   logic          overflow_q;
   logic          overflow_d;

   // arbitration results
   logic [N_IN-1:0] cand_s  [0:N_OUT-1];
   logic            grant_s [0:N_OUT-1];
   logic [SW-1:0]   win_s   [0:N_OUT-1];

   // candidate matrix: input i requests output j
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         cand_s[j] = '0;
         for (int i = 0; i < N_IN; i++) begin
            if (in_valid[i] && (in_dest[i] == DW'(j))) begin
               cand_s[j][i] = 1'b1;
            end else begin
               cand_s[j][i] = 1'b0;
            end
         end
      end
   end

   // per-output round-robin scan from rr_ptr; no grant without credit or in reset
   always_comb begin
      logic [SW-1:0] idx;
      idx = '0;
      for (int j = 0; j < N_OUT; j++) begin
         grant_s[j] = 1'b0;
         win_s[j]   = '0;
         for (int k = 0; k < N_IN; k++) begin
            idx = wrap_add(rr_ptr_q[j], k);
            if (rst_n && !grant_s[j] && (credit_q[j] != '0) && cand_s[j][idx]) begin
               grant_s[j] = 1'b1;
               win_s[j]   = idx;
            end else begin
               grant_s[j] = grant_s[j];
            end
         end
      end
   end

   // fan winners back to inputs; an input has one destination so at most one grant
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         in_ready[i] = 1'b0;
      end
      for (int j = 0; j < N_OUT; j++) begin
         if (grant_s[j]) begin
            in_ready[win_s[j]] = 1'b1;
         end else begin
            in_ready[win_s[j]] = in_ready[win_s[j]];
         end
      end
   end

   // next-state: pointer advance, select capture and credit accounting
   always_comb begin
      overflow_d = overflow_q;
      for (int j = 0; j < N_OUT; j++) begin
         rr_ptr_d[j] = rr_ptr_q[j];
         credit_d[j] = credit_q[j];
         xsel_d[j]   = xsel_q[j];
         xvalid_d[j] = 1'b0;
         if (grant_s[j]) begin
            xvalid_d[j] = 1'b1;
            xsel_d[j]   = win_s[j];
            rr_ptr_d[j] = wrap_add(win_s[j], 1);
         end else begin
            xvalid_d[j] = 1'b0;
         end
         if (grant_s[j] && !credit_return[j]) begin
            credit_d[j] = credit_q[j] - CRED_ONE;
         end else if (!grant_s[j] && credit_return[j]) begin
            if (credit_q[j] == CRED_FULL) begin
               // credit already full: saturate and flag the protocol error
               overflow_d = 1'b1;
            end else begin
               credit_d[j] = credit_q[j] + CRED_ONE;
            end
         end else begin
            // neither, or grant and return together: count unchanged
            credit_d[j] = credit_q[j];
         end
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         for (int j = 0; j < N_OUT; j++) begin
            rr_ptr_q[j] <= '0;
            credit_q[j] <= CRED_FULL;
            xsel_q[j]   <= '0;
            xvalid_q[j] <= 1'b0;
         end
      end else begin
         overflow_q <= overflow_d;
         for (int j = 0; j < N_OUT; j++) begin
            rr_ptr_q[j] <= rr_ptr_d[j];
            credit_q[j] <= credit_d[j];
            xsel_q[j]   <= xsel_d[j];
            xvalid_q[j] <= xvalid_d[j];
         end
      end
   end

   // registered outputs
   always_comb begin
      credit_overflow = overflow_q;
      for (int j = 0; j < N_OUT; j++) begin
         xbar_sel[j]   = xsel_q[j];
         xbar_valid[j] = xvalid_q[j];
      end
   end

endmodule
